// File: rtl/cook_timer_ctrl.sv
// cook_timer_ctrl: microwave cook timer sequencer.
// Captures MM:SS keypad entry as four BCD digits. Counts the time down once
// per prescaled tick. Drives the magnetron enable and the display digits.
// Optional feature macro: QUICK_START_EN (start at 00:00 loads 00:30; start
// while running adds 30 s, saturating at 99:59).
module cook_timer_ctrl #(
    parameter int CLK_DIV = 100
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       keypad_valid,
    input  logic [3:0] keypad_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       heating,
    output logic       done,
    output logic [1:0] state
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mu;
        logic [3:0] st;
        logic [3:0] su;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = '{mt: 4'd0, mu: 4'd0, st: 4'd0, su: 4'd0};
    localparam bcd_time_t TIME_ONE  = '{mt: 4'd0, mu: 4'd0, st: 4'd0, su: 4'd1};

    state_t    r_state, w_state_nx;
    bcd_time_t r_time,  w_time_nx;
    logic [PW-1:0] r_presc, w_presc_nx;
    logic      w_tick;
    logic      w_time_zero;

    // Digit-wise BCD decrement; caller guarantees time is nonzero.
    // Seconds tens borrows back to 5 so 01:00 becomes 00:59.
    function automatic bcd_time_t dec_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.su != 4'd0) begin
            r.su = t.su - 4'd1;
        end else begin
            r.su = 4'd9;
            if (t.st != 4'd0) begin
                r.st = t.st - 4'd1;
            end else begin
                r.st = 4'd5;
                if (t.mu != 4'd0) begin
                    r.mu = t.mu - 4'd1;
                end else begin
                    r.mu = 4'd9;
                    r.mt = t.mt - 4'd1;
                end
            end
        end
        return r;
    endfunction

`ifdef QUICK_START_EN
    // Add 30 s. A seconds-tens overflow past 5 wraps by 6 and carries one
    // minute; a carry out of 99 minutes pins the display at 99:59.
    function automatic bcd_time_t add30(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.st <= 4'd2) begin
            r.st = t.st + 4'd3;
        end else begin
            r.st = t.st - 4'd3;
            if (t.mu != 4'd9) begin
                r.mu = t.mu + 4'd1;
            end else if (t.mt != 4'd9) begin
                r.mu = 4'd0;
                r.mt = t.mt + 4'd1;
            end else begin
                r = '{mt: 4'd9, mu: 4'd9, st: 4'd5, su: 4'd9};
            end
        end
        return r;
    endfunction
`endif

    assign w_tick      = (r_state == RUNNING) && (r_presc == PRESC_LAST);
    assign w_time_zero = (r_time == TIME_ZERO);

    // Next-state, next-time and prescaler decode; first matching rule wins.
    always_comb begin
        w_state_nx = r_state;
        w_time_nx  = r_time;
        w_presc_nx = '0;
        case (r_state)
            IDLE: begin
                if (stop) begin
                    w_time_nx = TIME_ZERO;
                end else if (start && door_closed && !w_time_zero) begin
                    w_state_nx = RUNNING;
`ifdef QUICK_START_EN
                end else if (start && door_closed) begin
                    w_state_nx = RUNNING;
                    w_time_nx  = '{mt: 4'd0, mu: 4'd0, st: 4'd3, su: 4'd0};
`endif
                end else if (keypad_valid && (keypad_digit <= 4'd9)) begin
                    w_time_nx = '{mt: r_time.mu, mu: r_time.st,
                                  st: r_time.su, su: keypad_digit};
                end
            end
            RUNNING: begin
                if (stop || !door_closed) begin
                    // A tick landing on the pause edge is dropped on purpose.
                    w_state_nx = PAUSED;
                end else if (w_tick && (r_time == TIME_ONE)) begin
                    w_state_nx = DONE;
                    w_time_nx  = TIME_ZERO;
                end else begin
                    if (w_tick) begin
                        w_time_nx = dec_time(r_time);
                    end
`ifdef QUICK_START_EN
                    if (start) begin
                        w_time_nx = add30(w_time_nx);
                    end
`endif
                    w_presc_nx = w_tick ? '0 : PW'(r_presc + 1'b1);
                end
            end
            PAUSED: begin
                if (stop) begin
                    w_state_nx = IDLE;
                    w_time_nx  = TIME_ZERO;
                end else if (start && door_closed) begin
                    w_state_nx = RUNNING;
                end
            end
            DONE: begin
                if (stop || start) begin
                    w_state_nx = IDLE;
                    w_time_nx  = TIME_ZERO;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_time_nx  = TIME_ZERO;
            end
        endcase
    end

    // State, time and prescaler registers with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state <= IDLE;
            r_time  <= TIME_ZERO;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nx;
            r_time  <= w_time_nx;
            r_presc <= w_presc_nx;
        end
    end

    assign min_tens  = r_time.mt;
    assign min_units = r_time.mu;
    assign sec_tens  = r_time.st;
    assign sec_units = r_time.su;
    assign heating   = (r_state == RUNNING);
    assign done      = (r_state == DONE);
    assign state     = r_state;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Self-checking bench for cook_timer_ctrl (CLK_DIV=4): directed scenarios
// plus a randomized run against a seconds/minutes arithmetic model.
module tb_cook_timer_ctrl;

    localparam int CLK_DIV = 4;

    logic       clock = 1'b0;
    logic       clear, keypad_valid, start, stop, door_closed;
    logic [3:0] keypad_digit;
    logic [3:0] min_tens, min_units, sec_tens, sec_units;
    logic       heating, done;
    logic [1:0] state;
    logic [15:0] disp;

    int nvec = 0;
    int nerr = 0;

    // Model: minutes and seconds held as plain integers (seconds may be 60-99).
    int m_state, m_min, m_sec, m_cnt;

    cook_timer_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clock(clock), .clear(clear), .keypad_valid(keypad_valid),
        .keypad_digit(keypad_digit), .start(start), .stop(stop),
        .door_closed(door_closed), .min_tens(min_tens), .min_units(min_units),
        .sec_tens(sec_tens), .sec_units(sec_units), .heating(heating),
        .done(done), .state(state)
    );

    always #5 clock = ~clock;
    assign disp = {min_tens, min_units, sec_tens, sec_units};

    // Advance one clock, applying the spec rules to the model alongside.
    task automatic cyc();
        int ns, nmin, nsec, ncnt, v;
        bit tick, t0;
        ns = m_state; nmin = m_min; nsec = m_sec; ncnt = 0;
        tick = (m_state == 1) && (m_cnt == CLK_DIV - 1);
        t0 = (m_min == 0) && (m_sec == 0);
        if (!clear) begin
            ns = 0; nmin = 0; nsec = 0;
        end else begin
            case (m_state)
                0: begin
                    if (stop) begin
                        nmin = 0; nsec = 0;
                    end else if (start && door_closed && !t0) begin
                        ns = 1;
`ifdef QUICK_START_EN
                    end else if (start && door_closed) begin
                        ns = 1; nsec = 30;
`endif
                    end else if (keypad_valid && keypad_digit <= 9) begin
                        v = ((m_min * 100 + m_sec) * 10 + int'(keypad_digit)) % 10000;
                        nmin = v / 100; nsec = v % 100;
                    end
                end
                1: begin
                    if (stop || !door_closed) begin
                        ns = 2;
                    end else begin
                        if (tick) begin
                            if (m_sec > 0) nsec = m_sec - 1;
                            else begin nsec = 59; nmin = m_min - 1; end
                        end
                        if (tick && m_min == 0 && m_sec == 1) ns = 3;
`ifdef QUICK_START_EN
                        else if (start) begin
                            nsec = nsec + 30;
                            if (nsec >= 60) begin nsec = nsec - 60; nmin = nmin + 1; end
                            if (nmin > 99) begin nmin = 99; nsec = 59; end
                        end
`endif
                        if (ns == 1) ncnt = tick ? 0 : m_cnt + 1;
                    end
                end
                2: begin
                    if (stop) begin ns = 0; nmin = 0; nsec = 0; end
                    else if (start && door_closed) ns = 1;
                end
                default: begin
                    if (stop || start) begin ns = 0; nmin = 0; nsec = 0; end
                end
            endcase
        end
        @(posedge clock);
        #1;
        m_state = ns; m_min = nmin; m_sec = nsec; m_cnt = ncnt;
    endtask

    task automatic key(input int d);
        keypad_valid = 1'b1; keypad_digit = 4'(d);
        cyc();
        keypad_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear = 1'b0; cyc(); clear = 1'b1;
    endtask

    task automatic test_reset();
        start = 1'b1; stop = 1'b0; keypad_valid = 1'b1; keypad_digit = 4'd7;
        clear = 1'b0; cyc(); cyc();
        start = 1'b0; keypad_valid = 1'b0; clear = 1'b1;
        nvec++; if (state !== 2'd0) begin nerr++; $display("FAIL reset_state got %0d want 0", state); end
        nvec++; if (disp !== 16'h0000) begin nerr++; $display("FAIL reset_digits got %h want 0000", disp); end
        nvec++; if (heating !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL reset_flags got h=%b d=%b want 0 0", heating, done); end
    endtask

    task automatic test_entry();
        do_reset();
        key(1); key(3); key(0); key(12);
        nvec++; if (disp !== 16'h0130) begin nerr++; $display("FAIL entry_digits got %h want 0130", disp); end
        nvec++; if (state !== 2'd0) begin nerr++; $display("FAIL entry_state got %0d want 0", state); end
    endtask

    task automatic test_midrun_reset();
        do_reset();
        key(1); key(2); key(3);
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        nvec++; if (state !== 2'd1 || disp !== 16'h0123) begin nerr++; $display("FAIL midrun_pre got st=%0d %h want 1 0123", state, disp); end
        clear = 1'b0; cyc(); clear = 1'b1;
        nvec++; if (state !== 2'd0 || disp !== 16'h0000 || heating !== 1'b0 || done !== 1'b0)
            begin nerr++; $display("FAIL midrun_reset got st=%0d %h h=%b d=%b want 0 0000 0 0", state, disp, heating, done); end
    endtask

    task automatic test_countdown();
        do_reset();
        key(1); key(0); key(0);
        start = 1'b1; cyc(); start = 1'b0;
        nvec++; if (heating !== 1'b1 || state !== 2'd1) begin nerr++; $display("FAIL cd_start got h=%b st=%0d want 1 1", heating, state); end
        repeat (CLK_DIV - 1) cyc();
        nvec++; if (disp !== 16'h0100) begin nerr++; $display("FAIL cd_early got %h want 0100", disp); end
        cyc();
        nvec++; if (disp !== 16'h0059) begin nerr++; $display("FAIL cd_first_tick got %h want 0059", disp); end
        repeat (59 * CLK_DIV - 1) cyc();
        nvec++; if (disp !== 16'h0001 || state !== 2'd1) begin nerr++; $display("FAIL cd_last got %h st=%0d want 0001 1", disp, state); end
        cyc();
        nvec++; if (disp !== 16'h0000 || state !== 2'd3 || done !== 1'b1 || heating !== 1'b0)
            begin nerr++; $display("FAIL cd_done got %h st=%0d d=%b h=%b want 0000 3 1 0", disp, state, done, heating); end
        cyc();
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL cd_done_hold got %b want 1", done); end
        start = 1'b1; cyc(); start = 1'b0;
        nvec++; if (state !== 2'd0) begin nerr++; $display("FAIL cd_exit got %0d want 0", state); end
    endtask

    task automatic test_pause();
        do_reset();
        key(4); key(2);
        start = 1'b1; cyc(); start = 1'b0;
        repeat (CLK_DIV - 1) cyc();
        door_closed = 1'b0; cyc();
        nvec++; if (state !== 2'd2 || disp !== 16'h0042 || heating !== 1'b0)
            begin nerr++; $display("FAIL pause_tick got st=%0d %h h=%b want 2 0042 0", state, disp, heating); end
        start = 1'b1; cyc(); start = 1'b0;
        nvec++; if (state !== 2'd2) begin nerr++; $display("FAIL pause_door_open got %0d want 2", state); end
        door_closed = 1'b1; cyc();
        start = 1'b1; cyc(); start = 1'b0;
        nvec++; if (state !== 2'd1) begin nerr++; $display("FAIL pause_resume got %0d want 1", state); end
        repeat (CLK_DIV - 1) cyc();
        nvec++; if (disp !== 16'h0042) begin nerr++; $display("FAIL resume_early got %h want 0042", disp); end
        cyc();
        nvec++; if (disp !== 16'h0041) begin nerr++; $display("FAIL resume_tick got %h want 0041", disp); end
    endtask

    task automatic test_both();
        do_reset();
        key(5);
        start = 1'b1; cyc(); start = 1'b0;
        stop = 1'b1; cyc();
        nvec++; if (state !== 2'd2 || disp !== 16'h0005) begin nerr++; $display("FAIL both_pause got st=%0d %h want 2 0005", state, disp); end
        start = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        nvec++; if (state !== 2'd0 || disp !== 16'h0000) begin nerr++; $display("FAIL both_idle got st=%0d %h want 0 0000", state, disp); end
    endtask

    task automatic test_quick();
        do_reset();
        start = 1'b1; cyc(); start = 1'b0;
`ifdef QUICK_START_EN
        nvec++; if (state !== 2'd1 || disp !== 16'h0030) begin nerr++; $display("FAIL quick_load got st=%0d %h want 1 0030", state, disp); end
        do_reset();
        key(4); key(5);
        start = 1'b1; cyc(); cyc(); start = 1'b0;
        nvec++; if (disp !== 16'h0115) begin nerr++; $display("FAIL quick_add got %h want 0115", disp); end
`else
        nvec++; if (state !== 2'd0 || disp !== 16'h0000) begin nerr++; $display("FAIL quick_off got st=%0d %h want 0 0000", state, disp); end
`endif
    endtask

    task automatic test_random();
        logic [15:0] exp;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            clear        = ($urandom_range(0, 299) != 0);
            keypad_valid = ($urandom_range(0, 2) == 0);
            keypad_digit = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            start        = ($urandom_range(0, 7) == 0);
            stop         = ($urandom_range(0, 39) == 0);
            door_closed  = ($urandom_range(0, 24) != 0);
            cyc();
            exp = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
            nvec++;
            if (disp !== exp || state !== 2'(m_state) || heating !== (m_state == 1) || done !== (m_state == 3)) begin
                nerr++;
                $display("FAIL rand[%0d] got st=%0d %h h=%b d=%b want st=%0d %h", i, state, disp, heating, done, m_state, exp);
            end
        end
        clear = 1'b1; start = 1'b0; stop = 1'b0; keypad_valid = 1'b0; door_closed = 1'b1;
    endtask

    initial begin
        clear = 1'b0; keypad_valid = 1'b0; keypad_digit = 4'd0;
        start = 1'b0; stop = 1'b0; door_closed = 1'b1;
        m_state = 0; m_min = 0; m_sec = 0; m_cnt = 0;
        test_reset();
        test_entry();
        test_midrun_reset();
        test_countdown();
        test_pause();
        test_both();
        test_quick();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
